// File: rtl/wb_stage_pipe_if.sv
// Bus bundle for wb_stage_pipe: M-stage inputs, W-stage controls and W-stage outputs.
// master drives the M side and consumes W results; slave is the write-back stage.
interface wb_stage_pipe_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 64
);
    logic               StallW;
    logic               FlushW;
    logic               ValidM;
    logic               RegWriteM;
    logic [1:0]         ResultSrcM;
    logic [2:0]         Funct3M;
    logic [XLEN-1:0]    ReadDataM;
    logic [XLEN-1:0]    ALUResultM;
    logic [XLEN-1:0]    PCPlus4M;
    logic [XLEN-1:0]    ImmExtM;
    logic [RADDR_W-1:0] RdM;

    logic [XLEN-1:0]    ResultW;
    logic               RegWriteW;
    logic [RADDR_W-1:0] RdW;
    logic               ValidW;
    logic [CNT_W-1:0]   InstRetW;

    modport master (
        output StallW, FlushW, ValidM, RegWriteM, ResultSrcM, Funct3M,
               ReadDataM, ALUResultM, PCPlus4M, ImmExtM, RdM,
        input  ResultW, RegWriteW, RdW, ValidW, InstRetW
    );

    modport slave (
        input  StallW, FlushW, ValidM, RegWriteM, ResultSrcM, Funct3M,
               ReadDataM, ALUResultM, PCPlus4M, ImmExtM, RdM,
        output ResultW, RegWriteW, RdW, ValidW, InstRetW
    );
endinterface

// File: rtl/wb_stage_pipe.sv
// Write-back stage: MEM/WB pipeline register, load-data extraction, 4-way result
// select and register-file write qualification.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN;
// otherwise InstRetW is tied to zero.
module wb_stage_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 64
) (
    input logic            clk,
    input logic            rst_n,
    wb_stage_pipe_if.slave bus
);
    localparam int unsigned ShW  = $clog2(XLEN);
    localparam int unsigned OffW = ShW - 3;

    logic               valid_q;
    logic               regwrite_q;
    logic [RADDR_W-1:0] rd_q;
    logic [1:0]         src_q;
    logic [2:0]         funct3_q;
    logic [XLEN-1:0]    rdata_q;
    logic [XLEN-1:0]    alu_q;
    logic [XLEN-1:0]    pc4_q;
    logic [XLEN-1:0]    imm_q;

    // MEM/WB register: flush beats stall beats load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            src_q      <= '0;
            funct3_q   <= '0;
            rdata_q    <= '0;
            alu_q      <= '0;
            pc4_q      <= '0;
            imm_q      <= '0;
        end else if (bus.FlushW) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
        end else if (!bus.StallW) begin
            valid_q    <= bus.ValidM;
            regwrite_q <= bus.RegWriteM;
            rd_q       <= bus.RdM;
            src_q      <= bus.ResultSrcM;
            funct3_q   <= bus.Funct3M;
            rdata_q    <= bus.ReadDataM;
            alu_q      <= bus.ALUResultM;
            pc4_q      <= bus.PCPlus4M;
            imm_q      <= bus.ImmExtM;
        end
    end

    logic [OffW-1:0] off;
    logic [ShW-1:0]  byte_sh;
    logic [ShW-1:0]  half_sh;
    logic [ShW-1:0]  word_sh;
    logic [XLEN-1:0] byte_v;
    logic [XLEN-1:0] half_v;
    logic [XLEN-1:0] word_v;
    logic [7:0]      b;
    logic [15:0]     h;
    logic [31:0]     w;
    logic [XLEN-1:0] load_data;

    assign off     = alu_q[OffW-1:0];
    assign byte_sh = {off, 3'b000};
    // Halfword ignores offset bit 0.
    assign half_sh = {off[OffW-1:1], 4'b0000};

    // Word select only exists for XLEN=64; in RV32 the whole word is taken.
    always_comb begin
        word_sh = '0;
        if (XLEN == 64) word_sh = {off[OffW-1], {(OffW + 2){1'b0}}};
    end

    assign byte_v = rdata_q >> byte_sh;
    assign half_v = rdata_q >> half_sh;
    assign word_v = rdata_q >> word_sh;
    assign b      = byte_v[7:0];
    assign h      = half_v[15:0];
    assign w      = word_v[31:0];

    // Load extraction by funct3; unknown encodings pass the raw word through.
    always_comb begin
        load_data = rdata_q;
        case (funct3_q)
            3'b000:  load_data = XLEN'(signed'(b));
            3'b001:  load_data = XLEN'(signed'(h));
            3'b010:  load_data = XLEN'(signed'(w));
            3'b100:  load_data = XLEN'(b);
            3'b101:  load_data = XLEN'(h);
            3'b110:  if (XLEN == 64) load_data = XLEN'(w);
            default: load_data = rdata_q;
        endcase
    end

    // Result source select.
    always_comb begin
        bus.ResultW = alu_q;
        unique case (src_q)
            2'b00: bus.ResultW = alu_q;
            2'b01: bus.ResultW = load_data;
            2'b10: bus.ResultW = pc4_q;
            2'b11: bus.ResultW = imm_q;
        endcase
    end

    assign bus.ValidW    = valid_q;
    assign bus.RdW       = rd_q;
    // x0 is never written.
    assign bus.RegWriteW = regwrite_q & valid_q & (rd_q != '0);

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count each W instruction once, on the edge it leaves (not while stalled).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (valid_q && !bus.StallW) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.InstRetW = cnt_q;
`else
    assign bus.InstRetW = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/wb_stage_pipe.md
Name: wb_stage_pipe

Overview:
- Parametrised successor to the combinational write-back mux. Contains the MEM/WB pipeline register, load-data extraction (byte/half select with sign or zero extension), a 4-way result select that adds an immediate source, and register-file write qualification.
- Sits between the memory stage and the register file / hazard unit.
- Optionally counts retired instructions.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64.
- RADDR_W, 5, register address width.
- CNT_W, 64, retire counter width. Only used when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- StallW  in  1  hold the MEM/WB register
- FlushW  in  1  load a bubble into MEM/WB
- ValidM  in  1  M-stage slot holds a real instruction
- RegWriteM  in  1  register-file write request
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4, 11 immediate
- Funct3M  in  3  load type
- ReadDataM  in  XLEN  raw data-memory word
- ALUResultM  in  XLEN  ALU result; also the load address
- PCPlus4M  in  XLEN  PC+4
- ImmExtM  in  XLEN  extended immediate (LUI)
- RdM  in  RADDR_W  destination register
- ResultW  out  XLEN  write-back data
- RegWriteW  out  1  qualified register-file write enable
- RdW  out  RADDR_W  destination register
- ValidW  out  1  W-stage slot valid
- InstRetW  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n=0, asynchronous): every MEM/WB field clears to 0, so ValidW=0, RegWriteW=0, RdW=0 and ResultW=0. InstRetW=0.
- Latency: M-stage inputs sampled on a rising clk appear at the W outputs after that edge, i.e. 1 cycle. ResultW is combinational from the registered fields; no further delay.
- Register update priority, per edge: FlushW > StallW > load.
  - Flush: ValidW=0, RegWriteW=0, RdW=0; other fields don't-care.
  - Stall: all fields hold.
  - Otherwise: capture all M inputs.
- RegWriteW = registered RegWrite AND ValidW AND (RdW != 0). Writes to x0 never assert.
- Result select:
  - 00 → ALUResult
  - 01 → extracted load data
  - 10 → PC+4
  - 11 → ImmExt
- Load extraction: byte offset is off = ALUResultW[1:0] for XLEN=32, [2:0] for XLEN=64.
  - Funct3 000 LB: byte at off, sign-extended.
  - Funct3 001 LH: halfword at off with bit 0 ignored, sign-extended.
  - Funct3 010 LW: word; offset ignored for XLEN=32. For XLEN=64, word at off[2], sign-extended.
  - Funct3 100 LBU, 101 LHU: as LB/LH, zero-extended.
  - Funct3 110 (LWU, XLEN=64 only): word at off[2], zero-extended.
  - Any other Funct3: ReadData passed through unmodified.
- Misaligned offsets are not trapped here; low offset bits are ignored as stated above.
- Flush and stall asserted together: flush wins.
- Reset mid-stall: reset wins immediately, asynchronously.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- Defined:
  - InstRetW increments by 1 on each rising edge where ValidW=1 and StallW=0; a stalled instruction counts once.
  - Wraps modulo 2^CNT_W.
  - Cleared only by reset.
- Undefined: no counter logic; InstRetW is tied to 0.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with a valid instruction in W → ValidW=0, RegWriteW=0, ResultW=0 immediately, without waiting for a clock edge.
- Load extraction: ReadDataM=0x8001_F0FE, ResultSrcM=01.
  - LB, ALUResult=0x...00 → ResultW=0xFFFF_FFFE
  - LBU, off=3 → 0x0000_0080
  - LH, off=2 → 0xFFFF_8001
  - LHU, off=0 → 0x0000_F0FE
  - LW → 0x8001_F0FE
- Source select: ALU=0x11, PC+4=0x104, Imm=0xABCDE000; sweep ResultSrcM 00/10/11 → ResultW 0x11 / 0x104 / 0xABCDE000, each one cycle after capture.
- x0 suppression: RegWriteM=1, RdM=0, ValidM=1 → RegWriteW=0. Same with RdM=5 → RegWriteW=1, RdW=5.
- Stall/flush:
  - Capture Rd=7, then StallW=1 for 3 cycles with new M data → RdW stays 7.
  - StallW=1 together with FlushW=1 → ValidW=0, RegWriteW=0 next edge.
- Counter (WB_RETIRE_CNT_EN, CNT_W=4): 20 valid, unstalled cycles → InstRetW=4 (wrapped). 2 stalled cycles on one instruction count it once. Without the macro, InstRetW remains 0.
